// File: rtl/send_scheduler.sv
// send_scheduler: picks the next (segment, copy, round) for the TX frame builder,
// spaces frames by a programmable idle gap and watches the builder's busy response.
//
// Handshake with the frame builder: start_sending is a one-cycle request that carries
// segment_num/txid/aux/first_copy. The builder acknowledges by raising busy, which may
// already be high in the start cycle, and it signals completion by dropping busy. If busy
// never rises within BUSY_TO cycles, the frame counts as sent and timeout_err latches.
module send_scheduler #(
    parameter int SEG_W   = 16,
    parameter int TXID_W  = 8,
    parameter int AUX_W   = 8,
    parameter int GAP_W   = 28,
    parameter int BUSY_TO = 64
) (
    input  logic              clk125MHz,
    input  logic              RST_N,
    input  logic              enable,
    input  logic              mode,
    input  logic [SEG_W-1:0]  seg_count,
    input  logic [TXID_W-1:0] redundancy,
    input  logic [GAP_W-1:0]  gap_cycles,
    input  logic              busy,
    output logic              start_sending,
    output logic [SEG_W-1:0]  segment_num,
    output logic [TXID_W-1:0] txid,
    output logic [AUX_W-1:0]  aux,
    output logic              first_copy,
    output logic              round_done,
    output logic              timeout_err,
    output logic [2:0]        state_dbg
);

    localparam int TO_W = $clog2(BUSY_TO + 1);

    typedef enum logic [2:0] {IDLE, GAP, START, WAIT_BUSY, WAIT_DONE} state_t;

    state_t            state, state_nxt;
    logic [SEG_W-1:0]  seg, seg_last, seg_nxt, cfg_seg_last;
    logic [TXID_W-1:0] txid_cnt, r_max, txid_nxt, cfg_r_max;
    logic              mode_lat;
    logic [AUX_W-1:0]  aux_cnt;
    logic [GAP_W-1:0]  gap_tmr;
    logic [TO_W-1:0]   to_cnt;
    logic              advance, last_frame, to_hit, latch_cfg;

    // A programmed count of zero behaves as one segment / one copy.
    assign cfg_seg_last = (seg_count == '0) ? '0 : seg_count - 1'b1;
    assign cfg_r_max    = (redundancy == '0) ? TXID_W'(1) : redundancy;
    assign state_dbg    = state;

    // Next-state logic plus the sequence step taken when a frame is finished.
    always_comb begin
        state_nxt  = state;
        advance    = 1'b0;
        to_hit     = 1'b0;
        latch_cfg  = 1'b0;
        seg_nxt    = seg;
        txid_nxt   = txid_cnt;
        last_frame = 1'b0;

        case (state)
            IDLE: begin
                if (enable) begin
                    state_nxt = GAP;
                    latch_cfg = 1'b1;
                end
            end
            GAP: begin
                if (!busy && gap_tmr == gap_cycles) state_nxt = START;
            end
            START: state_nxt = WAIT_BUSY;
            WAIT_BUSY: begin
                if (busy) begin
                    state_nxt = WAIT_DONE;
                end else if (to_cnt == TO_W'(BUSY_TO - 1)) begin
                    to_hit  = 1'b1;
                    advance = 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!busy) advance = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase

        // mode 0 sweeps all segments per copy; mode 1 sends all copies of a segment first
        if (!mode_lat) begin
            if (seg == seg_last) begin
                seg_nxt = '0;
                if (txid_cnt == r_max) last_frame = 1'b1;
                else                   txid_nxt = txid_cnt + 1'b1;
            end else begin
                seg_nxt = seg + 1'b1;
            end
        end else begin
            if (txid_cnt == r_max) begin
                txid_nxt = TXID_W'(1);
                if (seg == seg_last) last_frame = 1'b1;
                else                 seg_nxt = seg + 1'b1;
            end else begin
                txid_nxt = txid_cnt + 1'b1;
            end
        end

        if (last_frame) begin
            seg_nxt  = '0;
            txid_nxt = TXID_W'(1);
        end

        if (advance) begin
            if (last_frame) begin
                latch_cfg = 1'b1;
                state_nxt = enable ? GAP : IDLE;
            end else begin
                state_nxt = GAP;
            end
        end
    end

    // State register.
    always_ff @(posedge clk125MHz or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_nxt;
    end

    // Counters, latched config, timers and registered outputs.
    always_ff @(posedge clk125MHz or negedge RST_N) begin
        if (!RST_N) begin
            seg           <= '0;
            txid_cnt      <= TXID_W'(1);
            aux_cnt       <= '0;
            seg_last      <= '0;
            r_max         <= '0;
            mode_lat      <= 1'b0;
            gap_tmr       <= '0;
            to_cnt        <= '0;
            start_sending <= 1'b0;
            segment_num   <= '0;
            txid          <= TXID_W'(1);
            aux           <= '0;
            first_copy    <= 1'b1;
            round_done    <= 1'b0;
            timeout_err   <= 1'b0;
        end else begin
            start_sending <= (state_nxt == START);
            round_done    <= advance && last_frame;
            if (to_hit) timeout_err <= 1'b1;

            if (latch_cfg) begin
                seg_last <= cfg_seg_last;
                r_max    <= cfg_r_max;
                mode_lat <= mode;
            end

            if (state == IDLE && enable) begin
                seg      <= '0;
                txid_cnt <= TXID_W'(1);
            end else if (advance) begin
                seg      <= seg_nxt;
                txid_cnt <= txid_nxt;
                if (last_frame) aux_cnt <= aux_cnt + 1'b1;
            end

            // gap timer is zero on GAP entry and restarts on any busy cycle
            if (state != GAP || busy) gap_tmr <= '0;
            else                      gap_tmr <= gap_tmr + 1'b1;

            if (state == WAIT_BUSY) to_cnt <= to_cnt + 1'b1;
            else                    to_cnt <= '0;

            // frame descriptor only changes when a new frame starts
            if (state_nxt == START) begin
                segment_num <= seg;
                txid        <= txid_cnt;
                aux         <= aux_cnt;
                first_copy  <= (txid_cnt == TXID_W'(1));
            end
        end
    end

endmodule

// File: tb/tb_send_scheduler.sv
// Testbench for send_scheduler: frame-level reference model (expected frame queue and
// start/round_done timestamps derived from the scheduling rules), randomized builder
// behaviour and config, plus directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_send_scheduler;

    localparam int SEG_W   = 16;
    localparam int TXID_W  = 8;
    localparam int AUX_W   = 8;
    localparam int GAP_W   = 28;
    localparam int BUSY_TO = 64;

    // ---------------- clock / reset ----------------
    logic              clk125MHz = 1'b0;
    logic              RST_N;
    logic              enable;
    logic              mode;
    logic [SEG_W-1:0]  seg_count;
    logic [TXID_W-1:0] redundancy;
    logic [GAP_W-1:0]  gap_cycles;
    logic              busy;
    logic              start_sending;
    logic [SEG_W-1:0]  segment_num;
    logic [TXID_W-1:0] txid;
    logic [AUX_W-1:0]  aux;
    logic              first_copy;
    logic              round_done;
    logic              timeout_err;
    logic [2:0]        state_dbg;

    always #4 clk125MHz = ~clk125MHz;

    send_scheduler #(
        .SEG_W(SEG_W), .TXID_W(TXID_W), .AUX_W(AUX_W), .GAP_W(GAP_W), .BUSY_TO(BUSY_TO)
    ) dut (
        .clk125MHz(clk125MHz), .RST_N(RST_N), .enable(enable), .mode(mode),
        .seg_count(seg_count), .redundancy(redundancy), .gap_cycles(gap_cycles),
        .busy(busy), .start_sending(start_sending), .segment_num(segment_num),
        .txid(txid), .aux(aux), .first_copy(first_copy), .round_done(round_done),
        .timeout_err(timeout_err), .state_dbg(state_dbg)
    );

    // ---------------- scoreboard / model state ----------------
    int n_cmp = 0;
    int n_fail = 0;
    logic [SEG_W+TXID_W-1:0] exp_q[$];     // expected {segment, txid} in send order
    int               k;                   // current cycle index
    bit               m_idle, in_gap, in_frame, to_frame, m_to;
    int               next_start, adv, b0, b1, rd_period, to_set;
    logic [AUX_W-1:0] m_aux, last_aux;
    logic [SEG_W-1:0] last_seg;
    logic [TXID_W-1:0] last_txid;

    // stimulus controls
    bit rand_on = 0, glitch_on = 0, to_force = 0;
    int fix_d = 0, fix_L = 3;

    // observations for directed literal checks
    int obs_seg[16], obs_txid[16], obs_aux[16], obs_fc[16], obs_cyc[16];
    int n_obs, n_rd;

    function automatic void chk(string nm, int act, int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0d expected %0d", nm, k, act, exp);
        end
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_idle = 1; in_gap = 0; in_frame = 0; to_frame = 0; m_to = 0;
        next_start = -1; adv = -1; b0 = -10; b1 = -10; rd_period = -1; to_set = -1;
        m_aux = '0; last_aux = '0; last_seg = '0; last_txid = TXID_W'(1);
    endtask

    // Build the whole round from the config as seen at this boundary.
    task automatic latch_push();
        int s_n, r_n;
        s_n = (seg_count == '0) ? 1 : int'(seg_count);
        r_n = (redundancy == '0) ? 1 : int'(redundancy);
        if (!mode) begin
            for (int t = 1; t <= r_n; t++)
                for (int s = 0; s < s_n; s++) exp_q.push_back({SEG_W'(s), TXID_W'(t)});
        end else begin
            for (int s = 0; s < s_n; s++)
                for (int t = 1; t <= r_n; t++) exp_q.push_back({SEG_W'(s), TXID_W'(t)});
        end
    endtask

    // One clock cycle: compare outputs, drive inputs, advance the model, move on.
    task automatic period();
        bit exp_start;
        bit bv;
        int d, len;
        logic [SEG_W+TXID_W-1:0] fr;

        exp_start = in_gap && (k == next_start);
        if (exp_start) begin
            chk("frame_queue_nonempty", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                fr = exp_q.pop_front();
                last_seg  = fr[SEG_W+TXID_W-1:TXID_W];
                last_txid = fr[TXID_W-1:0];
                last_aux  = m_aux;
            end
            in_gap = 0;
            in_frame = 1;
            if (to_force || (rand_on && $urandom_range(0, 9) == 0)) begin
                to_frame = 1; b0 = -10; b1 = -10; adv = k + BUSY_TO;
            end else begin
                to_frame = 0;
                if (rand_on) begin
                    d = int'($urandom_range(0, 6)) - 1;
                    len = int'($urandom_range(1, 12));
                    if (d < 0 && len < 2) len = 2;
                end else begin
                    d = fix_d; len = fix_L;
                end
                b0 = k + 1 + d; b1 = b0 + len - 1; adv = b1 + 1;
            end
        end
        if (k == to_set) m_to = 1;

        chk("start_sending", int'(start_sending), int'(exp_start));
        chk("round_done",    int'(round_done),    int'(k == rd_period));
        chk("timeout_err",   int'(timeout_err),   int'(m_to));
        chk("segment_num",   int'(segment_num),   int'(last_seg));
        chk("txid",          int'(txid),          int'(last_txid));
        chk("aux",           int'(aux),           int'(last_aux));
        chk("first_copy",    int'(first_copy),    int'(last_txid == TXID_W'(1)));

        if (start_sending) begin
            if (n_obs < 16) begin
                obs_seg[n_obs] = int'(segment_num); obs_txid[n_obs] = int'(txid);
                obs_aux[n_obs] = int'(aux); obs_fc[n_obs] = int'(first_copy);
                obs_cyc[n_obs] = k;
            end
            n_obs++;
        end
        if (round_done) n_rd++;

        // drive inputs for this cycle
        if (rand_on) begin
            if (!enable) enable = ($urandom_range(0, 99) < 20);
            else if ($urandom_range(0, 99) < 2) enable = 1'b0;
            if ($urandom_range(0, 99) < 5) begin
                seg_count  = SEG_W'($urandom_range(0, 4));
                redundancy = TXID_W'($urandom_range(0, 3));
                mode       = 1'($urandom_range(0, 1));
            end
            if (exp_start) gap_cycles = GAP_W'($urandom_range(0, 6));
        end
        bv = 0;
        if (in_frame && k >= b0 && k <= b1) begin
            bv = 1;
        end else if (in_gap && glitch_on && k < next_start && $urandom_range(0, 99) < 4) begin
            bv = 1;
            next_start = k + int'(gap_cycles) + 2;
        end
        busy = bv;

        // model decision at the end of this cycle
        if (m_idle) begin
            if (enable) begin
                latch_push();
                m_idle = 0; in_gap = 1; next_start = k + 2 + int'(gap_cycles);
            end
        end else if (in_frame && k == adv) begin
            in_frame = 0;
            if (to_frame) to_set = k + 1;
            if (exp_q.size() == 0) begin
                rd_period = k + 1;
                m_aux++;
                if (enable) begin
                    latch_push();
                    in_gap = 1; next_start = k + 2 + int'(gap_cycles);
                end else begin
                    m_idle = 1;
                end
            end else begin
                in_gap = 1; next_start = k + 2 + int'(gap_cycles);
            end
        end

        @(negedge clk125MHz);
        k++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) period();
    endtask

    task automatic clear_obs();
        n_obs = 0; n_rd = 0;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int es0[6] = '{0, 1, 2, 0, 1, 2};
        int et0[6] = '{1, 1, 1, 2, 2, 2};
        int es1[6] = '{0, 0, 1, 1, 2, 2};
        int et1[6] = '{1, 2, 1, 2, 1, 2};
        bit found;

        RST_N = 1'b0; enable = 1'b0; mode = 1'b0; seg_count = SEG_W'(3);
        redundancy = TXID_W'(2); gap_cycles = GAP_W'(4); busy = 1'b0;
        k = 0;
        model_reset();
        repeat (3) @(negedge clk125MHz);
        chk("reset_txid", int'(txid), 1);
        chk("reset_first_copy", int'(first_copy), 1);
        RST_N = 1'b1;
        model_reset();

        // frame-repeat order; enable dropped and S changed mid-round
        enable = 1'b1; fix_d = 0; fix_L = 3;
        clear_obs();
        run(12);
        enable = 1'b0; seg_count = SEG_W'(5);
        run(150);
        chk("mode0_frames", n_obs, 6);
        chk("mode0_round_done", n_rd, 1);
        for (int i = 0; i < 6; i++) begin
            chk("mode0_seg", obs_seg[i], es0[i]);
            chk("mode0_txid", obs_txid[i], et0[i]);
        end

        // segment-repeat order, second round
        mode = 1'b1; seg_count = SEG_W'(3); enable = 1'b1;
        clear_obs();
        run(12);
        enable = 1'b0;
        run(150);
        chk("mode1_frames", n_obs, 6);
        chk("mode1_aux", obs_aux[0], 1);
        for (int i = 0; i < 6; i++) begin
            chk("mode1_seg", obs_seg[i], es1[i]);
            chk("mode1_txid", obs_txid[i], et1[i]);
            chk("mode1_first_copy", obs_fc[i], (et1[i] == 1) ? 1 : 0);
        end

        // gap 10, builder busy 20 cycles per frame
        gap_cycles = GAP_W'(10); fix_L = 20; enable = 1'b1;
        clear_obs();
        run(100);
        chk("spacing_33_a", obs_cyc[1] - obs_cyc[0], 33);
        chk("spacing_33_b", obs_cyc[2] - obs_cyc[1], 33);
        enable = 1'b0;
        run(250);

        // builder never answers
        gap_cycles = GAP_W'(4); to_force = 1; enable = 1'b1;
        clear_obs();
        run(150);
        chk("timeout_spacing", obs_cyc[1] - obs_cyc[0], BUSY_TO + 4 + 2);
        chk("timeout_err_set", int'(timeout_err), 1);
        to_force = 0; fix_L = 3; enable = 1'b0;
        run(300);

        // randomized traffic, config churn and gap glitches
        rand_on = 1; glitch_on = 1;
        run(5000);
        rand_on = 0; glitch_on = 0;

        // async reset while the builder is busy
        fix_d = 0; fix_L = 30; enable = 1'b1;
        found = 0;
        for (int i = 0; i < 3000 && !found; i++) begin
            period();
            if (in_frame && !to_frame && k >= b0 + 2 && k < b1) found = 1;
        end
        chk("reached_wait_done", int'(found), 1);
        RST_N = 1'b0;
        #1;
        chk("arst_start_sending", int'(start_sending), 0);
        chk("arst_segment_num", int'(segment_num), 0);
        chk("arst_txid", int'(txid), 1);
        chk("arst_aux", int'(aux), 0);
        chk("arst_first_copy", int'(first_copy), 1);
        chk("arst_round_done", int'(round_done), 0);
        chk("arst_timeout_err", int'(timeout_err), 0);
        busy = 1'b0;
        @(negedge clk125MHz);
        k++;
        RST_N = 1'b1;
        model_reset();
        fix_L = 3;
        clear_obs();
        run(60);
        chk("restart_seg", obs_seg[0], 0);
        chk("restart_txid", obs_txid[0], 1);
        chk("restart_aux", obs_aux[0], 0);
        enable = 1'b0;
        run(200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
